// File: rtl/param_lifo.sv
// param_lifo: parametrised LIFO stack.
//   A pop returns the top word through a registered pop_data_o, qualified by
//   a one-cycle pop_valid_o. A push and a pop in the same cycle either bypass
//   (when the stack is empty) or replace the top entry.
//   Overflow and underflow are sticky until err_clr_i is asserted.
//   If an error happens in the same cycle as err_clr_i, the error flag stays set.
//
// Optional build macro: STACK_PEEK_EN
//   When defined, the block adds the ports top_data_o and top_valid_o,
//   which show the current top of stack without changing it.
//
// Ports:
//   clk, rstn        clock (rising edge), asynchronous active-low reset
//   push_i           push request
//   push_data_i      word to push
//   pop_i            pop request
//   err_clr_i        synchronous clear of overflow_o / underflow_o
//   pop_data_o       popped word (registered; holds while pop_valid_o is low)
//   pop_valid_o      one-cycle strobe: pop_data_o updated
//   count_o          occupancy, 0..DEPTH
//   full_o, empty_o, almost_full_o, almost_empty_o   status from count_o
//   overflow_o       sticky: a push was dropped
//   underflow_o      sticky: a pop arrived while empty
//   top_data_o       (STACK_PEEK_EN) current top word, 0 when empty
//   top_valid_o      (STACK_PEEK_EN) stack is not empty
module param_lifo #(
  parameter int DEPTH         = 16,
  parameter int WIDTH         = 8,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  input  logic                     err_clr_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     pop_valid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     almost_full_o,
  output logic                     almost_empty_o,
  output logic                     overflow_o,
  output logic                     underflow_o
`ifdef STACK_PEEK_EN
  ,
  output logic [WIDTH-1:0]         top_data_o,
  output logic                     top_valid_o
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

  // Storage is rounded up to a power of two so that the truncated address
  // always indexes a real entry. Entries at or above DEPTH are never used.
  logic [WIDTH-1:0] mem_q [2**AW];

  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] pop_data_q, pop_data_d;
  logic             pop_valid_q, pop_valid_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             full, empty;
  logic [AW-1:0]    top_addr, push_addr, mem_waddr;
  logic             mem_we;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign top_addr  = AW'(count_q - CW'(1));
  assign push_addr = AW'(count_q);

  always_comb begin
    count_d     = count_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    // The clear is applied first, so an error in the same cycle sets the flag again.
    ovf_d       = err_clr_i ? 1'b0 : ovf_q;
    unf_d       = err_clr_i ? 1'b0 : unf_q;
    mem_we      = 1'b0;
    mem_waddr   = push_addr;

    unique case ({push_i, pop_i})
      2'b10: begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          mem_we  = 1'b1;
          count_d = count_q + CW'(1);
        end
      end
      2'b01: begin
        if (empty) begin
          unf_d = 1'b1;
        end else begin
          pop_data_d  = mem_q[top_addr];
          pop_valid_d = 1'b1;
          count_d     = count_q - CW'(1);
        end
      end
      2'b11: begin
        pop_valid_d = 1'b1;
        if (empty) begin
          // The pushed word goes directly to the output and is never stored.
          pop_data_d = push_data_i;
        end else begin
          // Return the old top word and store the pushed word in its place.
          pop_data_d = mem_q[top_addr];
          mem_we     = 1'b1;
          mem_waddr  = top_addr;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q     <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  // The memory has no reset. Its contents are only read below count_q.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= push_data_i;
  end

  assign pop_data_o     = pop_data_q;
  assign pop_valid_o    = pop_valid_q;
  assign count_o        = count_q;
  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = (count_q >= AFULL_C);
  assign almost_empty_o = (count_q <= AEMPTY_C);
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;

`ifdef STACK_PEEK_EN
  assign top_data_o  = empty ? '0 : mem_q[top_addr];
  assign top_valid_o = !empty;
`endif

endmodule
